// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {IDLE, GNT} arb_state_t;

  // Covers up to eight requesters; callers slice off the low N_REQ bits.
  function automatic logic [7:0] onehot(input int unsigned id);
    logic [7:0] one;
    one = 8'd1;
    return one << id;
  endfunction

  function automatic int id_width(input int n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Requester/arbiter handshake bundle: level requests in, registered grant out.
interface rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             timeout;

  modport master (output req, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/rr_priority_enc.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping.
module rr_priority_enc #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  win_id,
  output logic             win_valid
);
  int idx;

  // Scan from the farthest offset down so the nearest hit lands last.
  always_comb begin
    win_id    = '0;
    win_valid = 1'b0;
    idx       = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (req[idx]) begin
        win_valid = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and an idle turnaround.
// Define RR_ARB_TIMEOUT_EN to preempt an owner holding MAX_HOLD cycles under contention.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_W     = id_width(N_REQ),
  parameter int MAX_HOLD = 16
) (
  input  logic         clock,
  input  logic         reset,
  rr_arbiter_if.slave  bus
);
  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic             to_q, to_d;
  logic [ID_W-1:0]  win_id;
  logic             win_valid;
  logic [7:0]       oh_win;
  logic [ID_W-1:0]  nxt_ptr;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD != 0);
`endif

  rr_priority_enc #(.N_REQ(N_REQ), .ID_W(ID_W)) u_enc (
    .req       (bus.req),
    .ptr       (ptr_q),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  assign nxt_ptr = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    to_d    = 1'b0;
    oh_win  = onehot(int'(win_id));
`ifdef RR_ARB_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = GNT;
          gnt_d   = oh_win[N_REQ-1:0];
          id_d    = win_id;
          busy_d  = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          hold_d  = HW'(1);
`endif
        end
      end
      GNT: begin
        if (!bus.req[id_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = nxt_ptr;
`ifdef RR_ARB_TIMEOUT_EN
          hold_d  = '0;
        end else if (hold_q == HW'(MAX_HOLD) && |(bus.req & ~gnt_q)) begin
          // Tenure expired with someone waiting: release and flag it.
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = nxt_ptr;
          to_d    = 1'b1;
          hold_d  = '0;
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d  = hold_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      to_q    <= to_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = to_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter (N_REQ=4, MAX_HOLD=4); follows RR_ARB_TIMEOUT_EN.
module tb_rr_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    int         at;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
    string      name;
  } exp_t;

  exp_t sb[$];

  rr_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

  rr_arbiter #(.N_REQ(4), .ID_W(2), .MAX_HOLD(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [3:0] oh(input int k);
    logic [3:0] one;
    one = 4'd1;
    return one << (k % 4);
  endfunction

  // Drive one cycle of inputs; expected outputs appear after the next edge.
  task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] eg,
                      input logic [1:0] eid, input logic eto, input string nm);
    exp_t e;
    @(posedge clock);
    #1;
    reset   = rst;
    bus.req = r;
    e.at   = cyc + 1;
    e.gnt  = eg;
    e.id   = eid;
    e.busy = |eg;
    e.to   = eto;
    e.name = nm;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (cyc > 0) begin
        checks++;
        if (!$onehot0(bus.gnt)) begin
          failures++;
          $display("FAIL onehot cyc=%0d gnt=%b", cyc, bus.gnt);
        end
      end
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (e.at != cyc || bus.gnt !== e.gnt || bus.busy !== e.busy ||
            bus.timeout !== e.to || (e.busy && bus.gnt_id !== e.id)) begin
          failures++;
          $display("FAIL %s cyc=%0d got gnt=%b id=%0d busy=%b to=%b want gnt=%b id=%0d busy=%b to=%b",
                   e.name, cyc, bus.gnt, bus.gnt_id, bus.busy, bus.timeout,
                   e.gnt, e.id, e.busy, e.to);
        end
      end
    end
  end

  initial begin : stim
    bus.req = 4'b0000;
    reset   = 1'b1;

    // Reset held with all requests pending, then first grant to 0.
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "reset0");
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "reset1");
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0, "first_gnt");

    // Fair rotation 0,1,2,3,0 with one idle cycle between owners.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'b1111, oh(k), 2'(k), 1'b0, "rot_hold");
      step(1'b0, 4'b1111 & ~oh(k), 4'b0000, 2'd0, 1'b0, "rot_gap");
      step(1'b0, 4'b1111, oh(k + 1), 2'((k + 1) % 4), 1'b0, "rot_next");
    end
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "rot_release");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle");

    // Single request: grant next cycle, release one cycle after drop.
    step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, "single_gnt");
    for (int k = 0; k < 4; k++) step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, "single_hold");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "single_drop");

    // Reset mid-grant restores ptr=0 (ptr would otherwise be 3).
    step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, "mid_gnt");
    step(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, "mid_reset");
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0, "post_reset_gnt");
    step(1'b0, 4'b1110, 4'b0000, 2'd0, 1'b0, "post_reset_drop");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle2");

    // Contention 0011: 4-cycle tenure then preemption when enabled.
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "to_reset");
    step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, "to_gnt");
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, "to_hold");
`ifdef RR_ARB_TIMEOUT_EN
    step(1'b0, 4'b0011, 4'b0000, 2'd0, 1'b1, "to_preempt");
    step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b0, "to_next");
`else
    step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, "to_keep");
    step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, "to_keep");
`endif
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "to_release");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle3");

    // Lone holder keeps grant; a late contender triggers preemption at once.
    step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0, "lone_gnt");
    for (int k = 0; k < 19; k++) step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0, "lone_hold");
`ifdef RR_ARB_TIMEOUT_EN
    step(1'b0, 4'b0011, 4'b0000, 2'd0, 1'b1, "late_preempt");
`else
    step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0, "late_keep");
`endif
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "late_release");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle4");

    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter sharing one single-owner resource (bus, memory port, shared engine) among `N_REQ` requesters.
- Requesters hold a level `req` for as long as they need the resource.
- The arbiter issues a registered one-hot grant and guarantees one idle turnaround cycle between owners.
- Optional tenure limit preempts an owner that hogs the resource while others wait.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `ID_W`, 2, width of `gnt_id`; equals `$clog2(N_REQ)`.
- `MAX_HOLD`, 16, maximum grant tenure in cycles under contention (≥2); used only with `RR_ARB_TIMEOUT_EN`.
- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in `N_REQ`: level request per requester.
- `gnt` out `N_REQ`: registered one-hot grant, or all zeros.
- `gnt_id` out `ID_W`: index of the current owner; valid when `busy`=1.
- `busy` out 1: 1 while any grant is asserted (OR of `gnt`).
- `timeout` out 1: one-cycle pulse marking a preemptive release.

## Operation
- **Reset values:** `gnt`=0, `gnt_id`=0, `busy`=0, `timeout`=0, `state`=IDLE, `ptr`=0, `hold_cnt`=0.
- **State machine:** two states, IDLE and GNT.
- **IDLE:**
  - If `req`≠0, select the winner by rotating priority: search from `ptr` upward, wrapping modulo `N_REQ`.
  - Go to GNT with `gnt`=onehot(winner), `gnt_id`=winner, `hold_cnt`=1.
  - If `req`=0, stay in IDLE.
- **GNT, normal release:** if `req[gnt_id]`=0, go to IDLE, set `gnt`=0, `ptr`=(`gnt_id`+1) mod `N_REQ`.
- **GNT, hold:** if `req[gnt_id]`=1, stay in GNT. Other requests never affect the owner unless preempted.
- **Pointer:** updates only on grant release, normal or preempted. Wrap from `N_REQ`-1 to 0.
- **Turnaround:** every release passes through IDLE, giving at least one cycle with `gnt`=0 between owners.
- **Re-request after release:** a requester that releases and immediately re-requests has the lowest priority at the next arbitration.
- **Reset mid-grant:** the next edge forces all reset values. No `timeout` pulse. `ptr` returns to 0.
- **Invariant:** `gnt` is never multi-hot.

## Timing
- **Grant latency:** `req` sampled high in an IDLE cycle → `gnt` high in the next cycle (1 cycle).
- **Release latency:** `req[owner]` sampled low in a GNT cycle → `gnt`=0 in the next cycle.
- **Minimum owner-to-owner gap:** exactly 1 idle cycle when another request is pending.
- **Idle arbitration:** a request arriving while IDLE with no prior owner sees the same 1-cycle latency.
- **Output timing:** all outputs are registered; no combinational path from `req` to any output.

## Configuration
- **Macro:** `RR_ARB_TIMEOUT_EN`.
- **Defined:**
  - `hold_cnt` counts grant cycles and saturates at `MAX_HOLD`.
  - In GNT, if `hold_cnt`=`MAX_HOLD`, `req[gnt_id]`=1 and any other `req` bit is 1, the arbiter preempts: go to IDLE, `gnt`=0, `timeout`=1 for that one idle cycle, `ptr`=`gnt_id`+1.
  - The owner therefore holds exactly `MAX_HOLD` cycles under contention.
  - With no contenders, the owner keeps the grant indefinitely. If a contender appears later, preemption happens at the first edge where the contender is sampled.
  - If the owner drops `req` in the same cycle preemption would fire, it is a normal release with `timeout`=0.
- **Undefined:** no counter, no preemption, `timeout` tied to 0, `MAX_HOLD` unused.

## Structure
- **Package `rr_arb_pkg`:**
  - state enum (IDLE, GNT)
  - function `onehot(id)`
  - function computing `ID_W` from `N_REQ`
- **Sub-module `rr_priority_enc`:** combinational rotating-priority encoder.
  - Inputs: `req`, `ptr`.
  - Outputs: `win_id`, `win_valid`.
  - Instantiated once in IDLE arbitration logic.

## Test plan
All scenarios use `N_REQ`=4 and `MAX_HOLD`=4.
- **Reset with requests:** `reset`=1 for 2 cycles with `req`=4'b1111 → `gnt`=0, `busy`=0, `timeout`=0 throughout. In the first cycle after reset deasserts the arbiter is IDLE with `gnt`=0; `gnt`=4'b0001, `gnt_id`=0 the cycle after.
- **Single request:** `req`=4'b0100 at cycle t → `gnt`=4'b0100, `gnt_id`=2 at t+1. Drop `req` at t+5 → `gnt`=0 at t+6.
- **Fair rotation:** all four request; each owner drops for one cycle after 2 grant cycles, then re-requests → grant order 0,1,2,3,0, with exactly one `gnt`=0 cycle between grants.
- **Timeout, macro on:** `req`=4'b0011 held → `gnt`=4'b0001 for exactly 4 cycles, then one cycle `gnt`=0 with `timeout`=1, then `gnt`=4'b0010.
- **Timeout, macro off:** same stimulus → `gnt`=4'b0001 persists and `timeout` stays 0.
- **Lone holder:** `req`=4'b0001 held 20 cycles, others 0 → `gnt`=4'b0001 continuous and `timeout` never asserts, macro on or off.
- **Reset mid-grant:** `reset` pulsed while `gnt`=4'b0100 → `gnt`=0 the next cycle. With `req`=4'b1111 after reset, the next grant goes to requester 0 (`ptr`=0), not requester 3.
